// File: rtl/tile_pkg.sv
// rtl/tile_pkg.sv - shared types and constants for the tile column loader
package tile_pkg;

  typedef enum logic [1:0] {TGT_TM, TGT_TS, TGT_PAL, TGT_RSVD} tgt_sel_t;
  typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} fsm_state_t;

  localparam int TILE_ROWS = 15;
  localparam int TILE_COLS = 20;
  localparam logic [3:0] LAST_ROW = 4'(TILE_ROWS - 1);
  localparam logic [4:0] LAST_COL = 5'(TILE_COLS - 1);

  // Tilemap is 32 columns wide in memory; only 20 are visible.
  function automatic logic [12:0] tm_cell_addr(input logic [3:0] row, input logic [4:0] col);
    return {4'b0000, row, col};
  endfunction

endpackage

// File: rtl/tile_fifo4.sv
// rtl/tile_fifo4.sv - 4-deep show-ahead FIFO carrying {row, level byte}
module tile_fifo4 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_push,
  input  logic [11:0] i_din,
  input  logic        i_pop,
  output logic [11:0] o_dout,
  output logic [2:0]  o_count
);

  logic [11:0] r_mem [0:3];
  logic [1:0]  r_wr_ptr;
  logic [1:0]  r_rd_ptr;
  logic [2:0]  r_count;
  logic        w_push;
  logic        w_pop;

  assign w_pop  = i_pop && (r_count != 3'd0);
  assign w_push = i_push && ((r_count != 3'd4) || w_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 3'd0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
      r_count <= r_count + {2'b00, w_push} - {2'b00, w_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/tile_column_loader.sv
// rtl/tile_column_loader.sv - host/column-fill arbiter for tilemap, tileset and palette ports
module tile_column_loader
  import tile_pkg::*;
#(
  parameter int LVL_ADDR_BITS = 20,
  parameter int SRC_BITS      = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     host_req,
  input  logic [1:0]               host_sel,
  input  logic                     host_we,
  input  logic [13:0]              host_addr,
  input  logic [23:0]              host_wdata,
  output logic                     host_gnt,
  output logic                     host_rvalid,
  output logic [23:0]              host_rdata,
  input  logic                     col_start,
  input  logic [4:0]               col_dst,
  input  logic [SRC_BITS-1:0]      col_src,
  output logic                     col_busy,
  output logic                     col_done,
  output logic                     col_err,
  output logic                     lvl_rd,
  output logic [LVL_ADDR_BITS-1:0] lvl_addr,
  input  logic [7:0]               lvl_rdata,
  output logic [12:0]              tm_address,
  output logic                     tm_we,
  output logic [7:0]               tm_din,
  input  logic [7:0]               tm_dout,
  output logic [13:0]              ts_address,
  output logic                     ts_we,
  output logic [3:0]               ts_din,
  input  logic [3:0]               ts_dout,
  output logic [3:0]               palette_address,
  output logic                     palette_we,
  output logic [23:0]              palette_din,
  input  logic [23:0]              palette_dout
);

  fsm_state_t          r_state;
  logic [4:0]          r_dst;
  logic [SRC_BITS-1:0] r_src;
  logic [3:0]          r_row;
  logic                r_pend;
  logic [3:0]          r_pend_row;
  logic                r_last_loader;
  logic                r_col_err;
  logic                r_rvalid;
  tgt_sel_t            r_rsel;

  tgt_sel_t            w_sel;
  logic [11:0]         w_fifo_dout;
  logic [2:0]          w_fifo_count;
  logic [2:0]          w_occ;
  logic                w_fifo_empty;
  logic                w_host_act;
  logic                w_host_tm;
  logic                w_host_ts;
  logic                w_host_pal;
  logic                w_conflict;
  logic                w_ld_wr;
  logic                w_gnt;
  logic                w_rd;
  logic                w_drained;

  tile_fifo4 u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (r_pend),
    .i_din   ({r_pend_row, lvl_rdata}),
    .i_pop   (w_ld_wr),
    .o_dout  (w_fifo_dout),
    .o_count (w_fifo_count)
  );

  assign w_sel        = tgt_sel_t'(host_sel);
  assign w_fifo_empty = (w_fifo_count == 3'd0);
  // Host is masked during reset so every port output reads zero while reset_n is low.
  assign w_host_act   = host_req && reset_n;
  assign w_host_tm    = w_host_act && (w_sel == TGT_TM);
  assign w_host_ts    = w_host_act && (w_sel == TGT_TS);
  assign w_host_pal   = w_host_act && (w_sel == TGT_PAL);
  assign w_conflict   = w_host_tm && !w_fifo_empty;
  assign w_ld_wr      = !w_fifo_empty && (!w_host_tm || !r_last_loader);
  assign w_gnt        = w_host_act && !(w_host_tm && w_ld_wr);

  // Outstanding reads count against FIFO space so captured data always fits.
  assign w_occ        = w_fifo_count + {2'b00, r_pend};
  assign w_rd         = (r_state == FILL) && (w_occ < 3'd4);
  assign w_drained    = (w_fifo_count == {2'b00, w_ld_wr}) && !r_pend;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_dst         <= 5'd0;
      r_src         <= '0;
      r_row         <= 4'd0;
      r_pend        <= 1'b0;
      r_pend_row    <= 4'd0;
      r_last_loader <= 1'b0;
      r_col_err     <= 1'b0;
      r_rvalid      <= 1'b0;
      r_rsel        <= TGT_TM;
    end else begin
      r_col_err  <= 1'b0;
      r_pend     <= w_rd;
      r_pend_row <= r_row;
      r_rvalid   <= w_gnt && !host_we;
      r_rsel     <= w_sel;
      if (w_conflict) r_last_loader <= w_ld_wr;
      case (r_state)
        IDLE: begin
          if (col_start) begin
            if (col_dst <= LAST_COL) begin
              r_dst   <= col_dst;
              r_src   <= col_src;
              r_row   <= 4'd0;
              r_state <= FILL;
            end else begin
              r_col_err <= 1'b1;
            end
          end
        end
        FILL: begin
          if (w_rd) begin
            r_row <= r_row + 4'd1;
            if (r_row == LAST_ROW) r_state <= DRAIN;
          end
        end
        DRAIN: if (w_drained) r_state <= DONE;
        DONE:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign col_busy = (r_state == FILL) || (r_state == DRAIN);
  assign col_done = (r_state == DONE);
  assign col_err  = r_col_err;
  assign lvl_rd   = w_rd;
  assign lvl_addr = w_rd ? {r_src, r_row} : '0;

  assign host_gnt    = w_gnt;
  assign host_rvalid = r_rvalid;

  assign tm_we      = w_ld_wr || (w_host_tm && w_gnt && host_we);
  assign tm_address = w_ld_wr ? tm_cell_addr(w_fifo_dout[11:8], r_dst) :
                      (w_host_tm && w_gnt) ? host_addr[12:0] : 13'd0;
  assign tm_din     = w_ld_wr ? w_fifo_dout[7:0] :
                      (w_host_tm && w_gnt && host_we) ? host_wdata[7:0] : 8'd0;

  assign ts_address      = w_host_ts ? host_addr : 14'd0;
  assign ts_we           = w_host_ts && host_we;
  assign ts_din          = ts_we ? host_wdata[3:0] : 4'd0;
  assign palette_address = w_host_pal ? host_addr[3:0] : 4'd0;
  assign palette_we      = w_host_pal && host_we;
  assign palette_din     = palette_we ? host_wdata : 24'd0;

  always_comb begin
    host_rdata = 24'd0;
    if (r_rvalid) begin
      case (r_rsel)
        TGT_TM:  host_rdata = {16'd0, tm_dout};
        TGT_TS:  host_rdata = {20'd0, ts_dout};
        TGT_PAL: host_rdata = palette_dout;
        default: host_rdata = 24'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_column_loader.sv
// tb/tb_tile_column_loader.sv - randomized and directed bench with a cycle-level reference model
module tb_tile_column_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        host_req;
  logic [1:0]  host_sel;
  logic        host_we;
  logic [13:0] host_addr;
  logic [23:0] host_wdata;
  logic        host_gnt;
  logic        host_rvalid;
  logic [23:0] host_rdata;
  logic        col_start;
  logic [4:0]  col_dst;
  logic [15:0] col_src;
  logic        col_busy;
  logic        col_done;
  logic        col_err;
  logic        lvl_rd;
  logic [19:0] lvl_addr;
  logic [7:0]  lvl_rdata;
  logic [12:0] tm_address;
  logic        tm_we;
  logic [7:0]  tm_din;
  logic [7:0]  tm_dout;
  logic [13:0] ts_address;
  logic        ts_we;
  logic [3:0]  ts_din;
  logic [3:0]  ts_dout;
  logic [3:0]  palette_address;
  logic        palette_we;
  logic [23:0] palette_din;
  logic [23:0] palette_dout;

  always #5 clk = ~clk;

  tile_column_loader #(.LVL_ADDR_BITS(20), .SRC_BITS(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .host_req(host_req), .host_sel(host_sel), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_gnt(host_gnt),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .col_start(col_start), .col_dst(col_dst), .col_src(col_src),
    .col_busy(col_busy), .col_done(col_done), .col_err(col_err),
    .lvl_rd(lvl_rd), .lvl_addr(lvl_addr), .lvl_rdata(lvl_rdata),
    .tm_address(tm_address), .tm_we(tm_we), .tm_din(tm_din), .tm_dout(tm_dout),
    .ts_address(ts_address), .ts_we(ts_we), .ts_din(ts_din), .ts_dout(ts_dout),
    .palette_address(palette_address), .palette_we(palette_we),
    .palette_din(palette_din), .palette_dout(palette_dout)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] key = 8'h00;

  logic [7:0]  tm_mem  [0:8191];
  logic [3:0]  ts_mem  [0:16383];
  logic [23:0] pal_mem [0:15];
  logic [7:0]  exp_tm  [0:8191];
  logic [3:0]  exp_ts  [0:16383];
  logic [23:0] exp_pal [0:15];

  function automatic logic [7:0] lvl_byte(input logic [3:0] row);
    return (8'h10 + {4'b0000, row}) ^ key;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memories and level storage surrounding the block
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tm_we) tm_mem[tm_address] <= tm_din;
    tm_dout <= tm_mem[tm_address];
    if (ts_we) ts_mem[ts_address] <= ts_din;
    ts_dout <= ts_mem[ts_address];
    if (palette_we) pal_mem[palette_address] <= palette_din;
    palette_dout <= pal_mem[palette_address];
    if (lvl_rd) lvl_rdata <= lvl_byte(lvl_addr[3:0]);
  end

  // Reference model state
  bit          m_busy, m_done, m_err, m_pend, m_last_loader, m_rv;
  logic [15:0] m_src;
  logic [4:0]  m_dst;
  int          m_issued, m_written, m_pend_row;
  int          q[$];
  logic [23:0] m_rdata;
  bit          e_rd, h_tm, conflict, ld, e_gnt, e_ts, e_pal, idle_m;
  int          done_cnt = 0, rd_cnt = 0, err_cyc = -1, done_cyc = -1;
  bit          seen_gnt = 1'b0;

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_col_busy", col_busy, 0);
      chk("rst_col_done", col_done, 0);
      chk("rst_col_err", col_err, 0);
      chk("rst_lvl_rd", lvl_rd, 0);
      chk("rst_tm_we", tm_we, 0);
      chk("rst_host_gnt", host_gnt, 0);
      chk("rst_host_rvalid", host_rvalid, 0);
      chk("rst_ts_we", ts_we, 0);
      chk("rst_palette_we", palette_we, 0);
      m_busy = 0; m_done = 0; m_err = 0; m_pend = 0; m_last_loader = 0; m_rv = 0;
      q.delete();
      seen_gnt = 0;
    end else begin
      e_rd     = m_busy && (m_issued < 15) && (q.size() + int'(m_pend) < 4);
      h_tm     = host_req && (host_sel == 2'd0);
      conflict = h_tm && (q.size() > 0);
      ld       = (q.size() > 0) && (!conflict || !m_last_loader);
      e_gnt    = host_req && !(h_tm && ld);
      e_ts     = host_req && (host_sel == 2'd1);
      e_pal    = host_req && (host_sel == 2'd2);

      chk("col_busy", col_busy, m_busy);
      chk("col_done", col_done, m_done);
      chk("col_err", col_err, m_err);
      chk("lvl_rd", lvl_rd, e_rd);
      if (e_rd) chk("lvl_addr", lvl_addr, {m_src, 4'(m_issued)});
      chk("host_gnt", host_gnt, e_gnt);
      chk("host_rvalid", host_rvalid, m_rv);
      if (m_rv) chk("host_rdata", host_rdata, m_rdata);
      chk("tm_we", tm_we, ld || (h_tm && e_gnt && host_we));
      if (ld) begin
        chk("tm_address_ld", tm_address, {4'b0000, 4'(q[0]), m_dst});
        chk("tm_din_ld", tm_din, lvl_byte(4'(q[0])));
      end else if (h_tm && e_gnt) begin
        chk("tm_address_host", tm_address, host_addr[12:0]);
        if (host_we) chk("tm_din_host", tm_din, host_wdata[7:0]);
      end
      chk("ts_we", ts_we, e_ts && host_we);
      if (e_ts) chk("ts_address", ts_address, host_addr);
      if (e_ts && host_we) chk("ts_din", ts_din, host_wdata[3:0]);
      chk("palette_we", palette_we, e_pal && host_we);
      if (e_pal) chk("palette_address", palette_address, host_addr[3:0]);
      if (e_pal && host_we) chk("palette_din", palette_din, host_wdata);

      m_rv = e_gnt && !host_we;
      if (m_rv) begin
        case (host_sel)
          2'd0:    m_rdata = {16'd0, exp_tm[host_addr[12:0]]};
          2'd1:    m_rdata = {20'd0, exp_ts[host_addr]};
          2'd2:    m_rdata = exp_pal[host_addr[3:0]];
          default: m_rdata = 24'd0;
        endcase
      end
      if (ld) begin
        exp_tm[{4'b0000, 4'(q[0]), m_dst}] = lvl_byte(4'(q[0]));
        void'(q.pop_front());
        m_written++;
      end
      if (h_tm && e_gnt && host_we) exp_tm[host_addr[12:0]] = host_wdata[7:0];
      if (e_ts && host_we) exp_ts[host_addr] = host_wdata[3:0];
      if (e_pal && host_we) exp_pal[host_addr[3:0]] = host_wdata;
      if (conflict) m_last_loader = ld;
      if (m_pend) q.push_back(m_pend_row);
      m_pend = e_rd;
      m_pend_row = m_issued;
      if (e_rd) m_issued++;

      idle_m = !m_busy && !m_done;
      m_err  = 0;
      m_done = 0;
      if (m_busy && ld && (m_written == 15)) begin
        m_busy = 0;
        m_done = 1;
      end
      if (idle_m && col_start) begin
        if (col_dst <= 5'd19) begin
          m_busy = 1; m_src = col_src; m_dst = col_dst; m_issued = 0; m_written = 0;
        end else begin
          m_err = 1;
        end
      end

      if (col_done) begin done_cnt++; done_cyc = cyc; end
      if (lvl_rd) rd_cnt++;
      if (col_err) err_cyc = cyc;
      seen_gnt = host_gnt;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_fill(input logic [15:0] src, input logic [4:0] dst, output int n);
    done_cyc  = -1;
    col_src   = src;
    col_dst   = dst;
    col_start = 1'b1;
    n = cyc;
    tick();
    col_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int n, input int budget, output int off);
    int k = 0;
    while (done_cyc < 0 && k < budget) begin
      tick();
      k++;
    end
    if (done_cyc < 0) begin
      chk({name, "_timeout"}, 0, 1);
      off = -1;
    end else begin
      off = done_cyc - n;
    end
  endtask

  task automatic rand_host();
    if (host_req && !seen_gnt) return;
    host_req   = ($urandom_range(0, 2) != 0);
    host_sel   = ($urandom_range(0, 1) == 1) ? 2'd0 : 2'($urandom);
    host_we    = 1'($urandom);
    host_addr  = 14'($urandom);
    host_wdata = 24'($urandom);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, off, d0, r0, budget, k;
    logic [15:0] src;
    logic [4:0]  dst;
    for (int i = 0; i < 8192; i++) begin tm_mem[i] = 8'd0; exp_tm[i] = 8'd0; end
    for (int i = 0; i < 16384; i++) begin ts_mem[i] = 4'd0; exp_ts[i] = 4'd0; end
    for (int i = 0; i < 16; i++) begin pal_mem[i] = 24'd0; exp_pal[i] = 24'd0; end
    lvl_rdata = 8'd0; tm_dout = 8'd0; ts_dout = 4'd0; palette_dout = 24'd0;
    reset_n = 1'b0; host_req = 1'b0; host_sel = 2'd0; host_we = 1'b0;
    host_addr = 14'd0; host_wdata = 24'd0; col_start = 1'b0; col_dst = 5'd0; col_src = 16'd0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // Uncontended fill
    key = 8'h00;
    start_fill(16'h0003, 5'd7, n);
    wait_done("t1", n, 60, off);
    chk("t1_done_latency", off, 18);
    tick();
    chk("t1_row0", tm_mem[13'h007], 8'h10);
    chk("t1_row1", tm_mem[13'h027], 8'h11);
    chk("t1_row14", tm_mem[13'h1C7], 8'h1E);

    // Host hammers tilemap writes during the fill
    host_req = 1'b1; host_sel = 2'd0; host_we = 1'b1; host_addr = 14'h0005; host_wdata = 24'h0000AA;
    start_fill(16'h0004, 5'd2, n);
    wait_done("t2", n, 80, off);
    host_req = 1'b0;
    chk("t2_done_latency", off, 32);
    tick();
    chk("t2_host_write", tm_mem[13'h005], 8'hAA);
    for (int r = 0; r < 15; r++) chk("t2_row", tm_mem[{4'b0000, 4'(r), 5'd2}], 32'(8'h10 + r));

    // Palette write and read-back alongside a fill
    key = 8'h33;
    host_req = 1'b1; host_sel = 2'd2; host_we = 1'b1; host_addr = 14'd3; host_wdata = 24'h123456;
    start_fill(16'h1234, 5'd19, n);
    host_we = 1'b0;
    #2 chk("t3_gnt_read", host_gnt, 1);
    tick();
    host_req = 1'b0;
    #2;
    chk("t3_rvalid", host_rvalid, 1);
    chk("t3_rdata", host_rdata, 24'h123456);
    wait_done("t3", n, 60, off);
    chk("t3_done_latency", off, 18);

    // Rejected destination
    r0 = rd_cnt;
    start_fill(16'h0001, 5'd20, n);
    #2;
    chk("t4_col_err", col_err, 1);
    chk("t4_col_busy", col_busy, 0);
    repeat (5) tick();
    chk("t4_err_cycle", err_cyc, n + 1);
    chk("t4_no_reads", rd_cnt - r0, 0);

    // Start while busy is ignored
    d0 = done_cnt; r0 = rd_cnt;
    start_fill(16'h00FF, 5'd0, n);
    repeat (4) tick();
    col_dst = 5'd3; col_start = 1'b1;
    tick();
    col_start = 1'b0;
    wait_done("t5", n, 60, off);
    repeat (25) tick();
    chk("t5_done_count", done_cnt - d0, 1);
    chk("t5_read_count", rd_cnt - r0, 15);

    // Reset in the middle of a fill
    start_fill(16'h0042, 5'd9, n);
    repeat (7) tick();
    d0 = done_cnt;
    reset_n = 1'b0;
    #2;
    chk("t6_busy_async", col_busy, 0);
    chk("t6_lvl_rd_async", lvl_rd, 0);
    chk("t6_tm_we_async", tm_we, 0);
    tick();
    reset_n = 1'b1;
    repeat (25) tick();
    chk("t6_no_done", done_cnt - d0, 0);
    start_fill(16'h0042, 5'd10, n);
    wait_done("t6", n, 60, off);
    chk("t6_refill_latency", off, 18);
    tick();

    // Randomized fills with random host traffic
    for (int f = 0; f < 12; f++) begin
      key = 8'($urandom);
      src = 16'($urandom);
      dst = 5'($urandom_range(0, 23));
      start_fill(src, dst, n);
      budget = (dst < 5'd20) ? 120 : 5;
      k = 0;
      while (k < budget && !(dst < 5'd20 && done_cyc >= 0)) begin
        rand_host();
        if (dst < 5'd20) begin
          col_start = ($urandom_range(0, 7) == 0);
          col_dst   = 5'($urandom_range(0, 23));
        end
        tick();
        k++;
      end
      col_start = 1'b0;
      host_req  = 1'b0;
      if (dst < 5'd20) chk("rnd_done_seen", done_cyc >= 0, 1);
      repeat (2) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tile_column_loader.md
Name: tile_column_loader

Overview:
- Memory-port controller for the tile display engine's host-side ports: tilemap, tileset and palette.
- Shares the tilemap write port between two requesters:
  - the host bus, which also gets sole access to the tileset and palette;
  - an autonomous column-fill engine that copies one 15-row level column from level storage into one tilemap column.
- Used for side-scrolling: software names a level column and a tilemap column, and the block streams the tiles while the host keeps running.
- Lives on the memory-port clock of the tile engine.

Parameters:
- LVL_ADDR_BITS, 20, level storage address width; level address = {col_src, row[3:0]}.
- SRC_BITS, 16, width of col_src; must equal LVL_ADDR_BITS-4.

Ports:
- clk  in  1  memory-port clock (same clock that drives the tile engine's memory ports).
- reset_n  in  1  reset, asynchronous, active-low.
- host_req  in  1  host access request; held until granted.
- host_sel  in  2  target: 0 tilemap, 1 tileset, 2 palette, 3 reserved.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  14  word address; truncated to 13/14/4 bits for tilemap/tileset/palette.
- host_wdata  in  24  write data; low 8/4/24 bits used.
- host_gnt  out  1  combinational grant for this cycle.
- host_rvalid  out  1  one-cycle pulse carrying read data.
- host_rdata  out  24  zero-extended read data.
- col_start  in  1  start-pulse for a column fill.
- col_dst  in  5  destination tilemap column, 0..19.
- col_src  in  SRC_BITS  source level column.
- col_busy  out  1  fill in progress.
- col_done  out  1  one-cycle pulse on completion.
- col_err  out  1  one-cycle pulse when a start is rejected.
- lvl_rd  out  1  level read strobe.
- lvl_addr  out  LVL_ADDR_BITS  level read address.
- lvl_rdata  in  8  level data, valid exactly 1 cycle after lvl_rd.
- tm_address  out  13;  tm_we  out  1;  tm_din  out  8;  tm_dout  in  8  tilemap port.
- ts_address  out  14;  ts_we  out  1;  ts_din  out  4;  ts_dout  in  4  tileset port.
- palette_address  out  4;  palette_we  out  1;  palette_din  out  24;  palette_dout  in  24  palette port.

Behaviour:
- Reset: all outputs 0; FSM returns to IDLE; FIFO empty; last_tm_winner = HOST. Reset mid-fill aborts the fill with no col_done; tilemap rows already written stay written.
- FSM states:
  - IDLE: on col_start with col_dst<=19, latch col_dst/col_src, clear row counter, go to FILL. On col_start with col_dst>=20, pulse col_err next cycle and stay in IDLE.
  - FILL: issue reads, then go to DRAIN after row 14 is issued.
  - DRAIN: go to DONE when the FIFO is empty and no read is outstanding.
  - DONE: one cycle; col_done=1, col_busy=0; then IDLE.
- col_busy is 1 in FILL and DRAIN only. col_start while busy is ignored (no col_err).
- Read issue: lvl_rd=1 with lvl_addr={col_src,row} whenever FIFO occupancy + outstanding reads < 4. The row counter increments per read, 0..14.
- Capture: lvl_rdata is pushed into a 4-entry FIFO together with its row, the cycle after lvl_rd.
- Loader write: when the FIFO is non-empty and the loader owns the tilemap port this cycle:
  - tm_we=1, tm_address={4'b0,row[3:0],col_dst}, tm_din=head data;
  - pop the head.
- Tilemap arbitration:
  - A conflict exists when host_req && host_sel==0 && FIFO non-empty.
  - On conflict the winner is the opposite of last_tm_winner, and last_tm_winner is updated. With no conflict the single requester wins and last_tm_winner is unchanged.
- Host access, sel 1/2, or sel 0 with the host winning: host_gnt=1 in the same cycle; the target port gets address/we/din from the host.
- Host reads: host_rvalid=1 the next cycle, with host_rdata = the registered-sel dout, zero-extended.
- Host writes: no rvalid.
- Reserved sel=3: granted immediately; no port activity; a read returns 0 with rvalid.
- Tileset and palette accesses never stall. host_gnt=0 only when the host loses a tilemap conflict.
- Uncontended timing, start sampled at cycle N:
  - col_busy from N+1;
  - lvl_rd row r at N+1+r;
  - tm_we row r at N+3+r;
  - col_done at N+18.
- Each lost conflict delays all later loader writes by one cycle. Reads self-throttle through the occupancy rule, so the FIFO never overflows.
- Back-to-back fills: a col_start arriving in the DONE cycle is ignored; one arriving in IDLE the cycle after is accepted.

Decomposition:
- Package tile_pkg holds:
  - enum tgt_sel_t {TGT_TM, TGT_TS, TGT_PAL, TGT_RSVD};
  - TILE_ROWS=15, TILE_COLS=20;
  - fsm_state_t {IDLE, FILL, DRAIN, DONE}.
- One sub-module: tile_fifo4, a 4-deep, 12-bit, show-ahead FIFO (8 data + 4 row) with push/pop/count.

Test Plan:
- Uncontended fill: col_src=0x0003, col_dst=7, level byte = 0x10+row -> 15 writes at tm_address 0x007,0x027..0x1C7 with data 0x10..0x1E; col_done at N+18; no host_gnt drop.
- Host conflict: host writes tilemap addr 0x005 data 0xAA continuously during the fill -> grants alternate, loader first; all 15 loader rows and every host write land; col_done is delayed by the number of loader-lost cycles.
- Host on tileset/palette during a fill: palette write addr 3 data 0x12_34_56, then read -> host_gnt never drops; rvalid next cycle with 0x123456; fill timing unchanged.
- Bad destination: col_start with col_dst=20 -> col_err pulse at N+1; col_busy stays 0; no lvl_rd.
- Start while busy: second col_start at N+5 -> ignored; exactly one col_done; lvl_rd count 15.
- Reset mid-fill: reset_n low at N+8 -> all outputs 0 at once; no col_done; a new fill afterwards completes normally.
